// File: rtl/mem_access_stage.sv
// ============================================================================
//  mem_access_stage : MIPS MEM stage - branch resolve, req/ack data memory FSM,
//                     MEM/WB result registers.   Rev 1.0
// ============================================================================
`default_nettype none

module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  mem_size_in,
  input  logic        mem_unsigned_in,
  input  logic        branch_in,
  input  logic        alu_zero_in,
  input  logic [31:0] pc_branch_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] read_data2_in,
  input  logic [4:0]  reg_dest_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] pc_branch_out,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [4:0]  wb_reg_dest,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_load_data,
  output logic        misalign_exc,
  output logic        bus_err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_timer;
  logic        w_memop;
  logic        w_aligned;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_memop       = in_valid & (mem_read_in | mem_write_in);
  assign w_timeout     = (r_timer == c_TMO_LAST);
  assign pc_src        = in_valid & branch_in & alu_zero_in & ~stall;
  assign pc_branch_out = pc_branch_in;

  always_comb begin
    w_aligned = 1'b1;
    w_be      = 4'hF;
    w_wdata   = read_data2_in;
    case (mem_size_in)
      2'd0: begin
        w_be    = 4'b0001 << alu_result_in[1:0];
        w_wdata = {4{read_data2_in[7:0]}};
      end
      2'd1: begin
        w_aligned = ~alu_result_in[0];
        w_be      = alu_result_in[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{read_data2_in[15:0]}};
      end
      default: w_aligned = (alu_result_in[1:0] == 2'b00);
    endcase
  end

  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (alu_result_in[1:0])
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = alu_result_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (mem_size_in)
      2'd0:    w_load_data = {{24{w_byte[7] & ~mem_unsigned_in}}, w_byte};
      2'd1:    w_load_data = {{16{w_half[15] & ~mem_unsigned_in}}, w_half};
      default: w_load_data = dmem_rdata;
    endcase
    if (!mem_read_in) w_load_data = 32'h0;
  end

  // A timed-out access releases the stall so the aborted instruction retires.
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_memop && w_aligned) begin
          stall       = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_ack || w_timeout) w_state_nxt = S_IDLE;
        else                       stall       = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer       <= 8'h0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'h0;
      dmem_wdata    <= 32'h0;
      dmem_be       <= 4'h0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_dest   <= 5'h0;
      wb_alu_result <= 32'h0;
      wb_load_data  <= 32'h0;
      misalign_exc  <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_timer <= 8'h0;
          if (w_memop && w_aligned) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_in;
            dmem_addr  <= {alu_result_in[31:2], 2'b00};
            dmem_wdata <= w_wdata;
            dmem_be    <= w_be;
            wb_valid   <= 1'b0;
          end else begin
            wb_valid      <= in_valid;
            wb_reg_write  <= reg_write_in & in_valid & ~w_memop;
            wb_mem_to_reg <= mem_to_reg_in;
            wb_reg_dest   <= reg_dest_in;
            wb_alu_result <= alu_result_in;
            wb_load_data  <= 32'h0;
            misalign_exc  <= w_memop;
          end
        end
        S_WAIT: begin
          if (dmem_ack || w_timeout) begin
            dmem_req      <= 1'b0;
            wb_valid      <= 1'b1;
            wb_reg_write  <= dmem_ack & reg_write_in & in_valid;
            wb_mem_to_reg <= mem_to_reg_in;
            wb_reg_dest   <= reg_dest_in;
            wb_alu_result <= alu_result_in;
            wb_load_data  <= dmem_ack ? w_load_data : 32'h0;
            bus_err       <= ~dmem_ack;
          end else begin
            r_timer  <= r_timer + 8'h1;
            wb_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
//  tb_mem_access_stage : directed + random checks of mem_access_stage against
//                        an arithmetic reference model.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 0, mem_read_in = 0, mem_write_in = 0, mem_unsigned_in = 0;
  logic [1:0]  mem_size_in = 0;
  logic        branch_in = 0, alu_zero_in = 0, reg_write_in = 0, mem_to_reg_in = 0;
  logic [31:0] pc_branch_in = 0, alu_result_in = 0, read_data2_in = 0, dmem_rdata = 0;
  logic [4:0]  reg_dest_in = 0;
  logic        dmem_ack = 0;
  logic        dmem_req, dmem_we, stall, pc_src;
  logic [31:0] dmem_addr, dmem_wdata, pc_branch_out, wb_alu_result, wb_load_data;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg, misalign_exc, bus_err;
  logic [4:0]  wb_reg_dest;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_size_in(mem_size_in),
    .mem_unsigned_in(mem_unsigned_in), .branch_in(branch_in),
    .alu_zero_in(alu_zero_in), .pc_branch_in(pc_branch_in),
    .alu_result_in(alu_result_in), .read_data2_in(read_data2_in),
    .reg_dest_in(reg_dest_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
    .pc_src(pc_src), .pc_branch_out(pc_branch_out), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_reg_dest(wb_reg_dest), .wb_alu_result(wb_alu_result),
    .wb_load_data(wb_load_data), .misalign_exc(misalign_exc), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ack_at = k: ack on the k-th waiting cycle; 0 = never acked.
  task automatic run_instr(input logic v, rd, wr, input logic [1:0] sz, input logic uns,
                           input logic br, z, input logic [31:0] pcb, addr, rd2,
                           input logic [4:0] dest, input logic rw, m2r,
                           input int ack_at, input logic [31:0] rdata);
    int          nbytes, lane, stalls, exp_stalls;
    logic        memop, aligned;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_load;
    in_valid = v; mem_read_in = rd; mem_write_in = wr; mem_size_in = sz;
    mem_unsigned_in = uns; branch_in = br; alu_zero_in = z; pc_branch_in = pcb;
    alu_result_in = addr; read_data2_in = rd2; reg_dest_in = dest;
    reg_write_in = rw; mem_to_reg_in = m2r;

    memop   = v & (rd | wr);
    nbytes  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    aligned = (addr % nbytes) == 0;
    lane    = int'(addr % 4) / nbytes * nbytes;
    e_be    = 4'(((1 << nbytes) - 1) << lane);
    e_wdata = (nbytes == 1) ? rd2[7:0] * 32'h01010101 :
              (nbytes == 2) ? rd2[15:0] * 32'h00010001 : rd2;
    e_load  = (rdata >> (8 * lane)) % (64'd1 << (8 * nbytes));
    if (!uns && nbytes < 4 && e_load >= (32'd1 << (8 * nbytes - 1)))
      e_load = e_load - (32'd1 << (8 * nbytes));
    if (!rd) e_load = 0;
    exp_stalls = (ack_at >= 1 && ack_at <= TMO) ? ack_at : TMO;
    if (!(memop && aligned)) exp_stalls = 0;
    stalls = 0;

    if (memop && aligned) begin
      #1;
      check("stall_issue", 32'(stall), 32'd1);
      check("pc_src_mem", 32'(pc_src), 32'd0);
      stalls++;
      tick();
      check("req", 32'(dmem_req), 32'd1);
      check("we", 32'(dmem_we), 32'(wr));
      check("addr", dmem_addr, addr & 32'hFFFF_FFFC);
      check("wdata", dmem_wdata, e_wdata);
      check("be", 32'(dmem_be), 32'(e_be));
      check("bubble", 32'(wb_valid), 32'd0);
      for (int w = 1; w <= TMO; w++) begin
        if (w == ack_at) begin
          dmem_ack = 1'b1; dmem_rdata = rdata;
          #1;
          check("stall_ack", 32'(stall), 32'd0);
          tick();
          dmem_ack = 1'b0; dmem_rdata = $urandom;
          check("wb_valid_ld", 32'(wb_valid), 32'd1);
          check("wb_rw_ld", 32'(wb_reg_write), 32'(rw));
          check("wb_load", wb_load_data, e_load);
          check("wb_m2r", 32'(wb_mem_to_reg), 32'(m2r));
          check("req_drop", 32'(dmem_req), 32'd0);
          check("bus_err_ack", 32'(bus_err), 32'd0);
          break;
        end else if (w == TMO) begin
          #1;
          check("stall_tmo", 32'(stall), 32'd0);
          tick();
          check("bus_err", 32'(bus_err), 32'd1);
          check("req_tmo", 32'(dmem_req), 32'd0);
          check("wb_valid_tmo", 32'(wb_valid), 32'd1);
          check("wb_rw_tmo", 32'(wb_reg_write), 32'd0);
          break;
        end else begin
          #1;
          check("stall_wait", 32'(stall), 32'd1);
          stalls++;
          tick();
          check("req_hold", 32'(dmem_req), 32'd1);
          check("bubble_wait", 32'(wb_valid), 32'd0);
        end
      end
    end else begin
      dmem_ack = 1'($urandom);
      #1;
      check("stall_none", 32'(stall), 32'd0);
      check("pc_src", 32'(pc_src), 32'(v & br & z));
      check("pc_target", pc_branch_out, pcb);
      tick();
      dmem_ack = 1'b0;
      check("wb_valid", 32'(wb_valid), 32'(v));
      check("wb_rw", 32'(wb_reg_write), 32'(v & rw & ~memop));
      check("wb_load0", wb_load_data, 32'd0);
      check("misalign", 32'(misalign_exc), 32'(memop));
      check("no_req", 32'(dmem_req), 32'd0);
    end
    check("stall_count", 32'(stalls), 32'(exp_stalls));
    check("wb_alu", wb_alu_result, addr);
    check("wb_dest", 32'(wb_reg_dest), 32'(dest));
    #1;
    check("pulse_clear", 32'(pc_src & ~(v & br & z)), 32'd0);
  endtask

  initial begin
    tick(); tick();
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_load", wb_load_data, 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;

    // lw 0x10, ack on 3rd waiting cycle
    run_instr(1, 1, 0, 2'd2, 0, 0, 0, 0, 32'h10, 0, 5'd3, 1, 1, 3, 32'hDEADBEEF);
    // lb / lbu 0x13
    run_instr(1, 1, 0, 2'd0, 0, 0, 0, 0, 32'h13, 0, 5'd4, 1, 1, 1, 32'h80FF_0000);
    run_instr(1, 1, 0, 2'd0, 1, 0, 0, 0, 32'h13, 0, 5'd5, 1, 1, 2, 32'h80FF_0000);
    // sh 0x22
    run_instr(1, 0, 1, 2'd1, 0, 0, 0, 0, 32'h22, 32'h1234ABCD, 5'd0, 0, 0, 1, 0);
    // misaligned lw
    run_instr(1, 1, 0, 2'd2, 0, 0, 0, 0, 32'h06, 0, 5'd6, 1, 1, 1, 0);
    // timeout, then a normal load
    run_instr(1, 1, 0, 2'd2, 0, 0, 0, 0, 32'h40, 0, 5'd7, 1, 1, 0, 0);
    run_instr(1, 1, 0, 2'd1, 0, 0, 0, 0, 32'h42, 0, 5'd8, 1, 1, 4, 32'h8001_0000);
    // taken beq, untaken beq, invalid slot
    run_instr(1, 0, 0, 2'd2, 0, 1, 1, 32'h0000_1000, 32'h0, 0, 5'd0, 0, 0, 0, 0);
    run_instr(1, 0, 0, 2'd2, 0, 1, 0, 32'h0000_2000, 32'h5, 0, 5'd0, 0, 0, 0, 0);
    run_instr(0, 1, 0, 2'd2, 0, 1, 1, 32'h0000_3000, 32'h8, 0, 5'd9, 1, 0, 1, 0);

    for (int i = 0; i < 300; i++) begin
      logic [2:0] kind;
      logic       rd, wr;
      kind = 3'($urandom_range(0, 5));
      rd   = (kind == 3'd0 || kind == 3'd1);
      wr   = (kind == 3'd2);
      run_instr(kind != 3'd5, rd, wr, 2'($urandom), 1'($urandom),
                kind == 3'd3, 1'($urandom), $urandom,
                (kind <= 3'd2 && $urandom_range(0, 3) != 0) ? ($urandom & 32'hFFFF_FFFC) |
                  (32'($urandom_range(0, 1)) << 1) : $urandom,
                $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, TMO + 1), $urandom);
    end

    // reset during an outstanding access
    in_valid = 1; mem_read_in = 1; mem_write_in = 0; mem_size_in = 2'd2;
    branch_in = 0; alu_result_in = 32'h80; reg_write_in = 1;
    tick();
    check("pre_rst_req", 32'(dmem_req), 32'd1);
    rst = 1'b1; in_valid = 0;
    tick();
    check("rst_mid_req", 32'(dmem_req), 32'd0);
    check("rst_mid_wbv", 32'(wb_valid), 32'd0);
    check("rst_mid_be", 32'(dmem_be), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    run_instr(1, 1, 0, 2'd2, 0, 0, 0, 0, 32'h84, 0, 5'd10, 1, 0, 1, 32'h0BAD_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
